// File: rtl/oled_pkg.sv
// oled_pkg: shared OLED geometry, receiver FSM encoding and pixel index helper
package oled_pkg;
  localparam int OLED_WIDTH = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int DEFAULT_NUM_PIXELS = OLED_WIDTH * OLED_HEIGHT;
  typedef enum logic [1:0] {IDLE, SHIFT, BYTE_DONE} state_t;
  function automatic logic [12:0] next_index(input logic [12:0] idx, input int n);
    return (int'(idx) == n - 1) ? 13'd0 : idx + 13'd1;
  endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-stage synchronizer bringing one asynchronous input into clk
module sync_ff #(
  parameter int DEPTH = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] stages;
  // shift the raw input through DEPTH flops, oldest sample at the top
  always_ff @(posedge clk)
    stages <= reset ? {DEPTH{RST_VAL}} : DEPTH'({stages, d});
  assign q = stages[DEPTH-1];
endmodule

// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver: decodes OLED SPI traffic into command bytes and RGB565 pixels
module oled_spi_receiver
  import oled_pkg::*;
#(
  parameter int NUM_PIXELS = DEFAULT_NUM_PIXELS,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sclk,
  input  logic        sdin,
  input  logic        d_cn,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [12:0] pix_index,
  output logic        frame_start,
  output logic        frag_err
);
  logic cs_s, sclk_s, sdin_s, dcn_s, sclk_prev, pend, rise, done, abort;
  logic [7:0] shreg, high, byte_in;
  logic [2:0] bit_cnt;
  state_t state, state_n;
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_cs   (.clk(clk), .reset(reset), .d(cs),   .q(cs_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (.clk(clk), .reset(reset), .d(sclk), .q(sclk_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sdin (.clk(clk), .reset(reset), .d(sdin), .q(sdin_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_dcn  (.clk(clk), .reset(reset), .d(d_cn), .q(dcn_s));
  assign rise = sclk_s & ~sclk_prev & ~cs_s;
  assign done = rise & (bit_cnt == 3'd7);
  assign abort = cs_s & (bit_cnt != 3'd0);
  assign byte_in = {shreg[6:0], sdin_s};
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // byte framing: wait for cs, collect 8 bits, then one cycle to hand the byte off
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = cs_s ? IDLE : SHIFT;
      SHIFT:   state_n = done ? BYTE_DONE : (cs_s ? IDLE : SHIFT);
      default: state_n = cs_s ? IDLE : SHIFT;
    endcase
  end
  // bit shifter; a cs rise mid-byte throws away the partial byte
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_prev <= 1'b1;
      shreg <= '0;
      bit_cnt <= '0;
    end else begin
      sclk_prev <= sclk_s;
      if (abort) begin
        shreg <= '0;
        bit_cnt <= '0;
      end else if (rise) begin
        shreg <= byte_in;
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end
  // byte decode: commands, high/low pixel pairing, index tracking and error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      pix_valid <= 1'b0;
      frame_start <= 1'b0;
      frag_err <= 1'b0;
      cmd_byte <= '0;
      pix_data <= '0;
      pix_index <= '0;
      high <= '0;
      pend <= 1'b0;
    end else begin
      cmd_valid <= done & ~dcn_s;
      pix_valid <= done & dcn_s & pend;
      frame_start <= done & dcn_s & pend & (pix_index == '0);
      frag_err <= abort | (done & ~dcn_s & pend);
      if (done & ~dcn_s) begin
        cmd_byte <= byte_in;
        pix_index <= '0;
        pend <= 1'b0;
      end else if (done & pend) begin
        pix_data <= {high, byte_in};
        pend <= 1'b0;
      end else if (done) begin
        high <= byte_in;
        pend <= 1'b1;
      end else if (pix_valid) begin
        pix_index <= next_index(pix_index, NUM_PIXELS);
      end
    end
  end
endmodule
